// File: rtl/adder_tree_pipe_pkg.sv
// -----------------------------------------------------------------------------
// adder_tree_pkg
// Shared compile-time helpers for the pipelined adder tree: ceiling log2,
// tree depth, full-precision sum width, and per-level element width/count.
// Also holds the control sideband type carried alongside the tree data.
// -----------------------------------------------------------------------------
package adder_tree_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // Number of pairwise-add levels needed to reduce num_in operands to one.
    function automatic int levels(input int num_in);
        return clog2(num_in);
    endfunction

    // Width that holds num_in operands plus the bias without overflow.
    function automatic int sum_w(input int in_w, input int num_in);
        return in_w + clog2(num_in + 1);
    endfunction

    // Width of each element entering tree level lvl.
    function automatic int level_w(input int in_w, input int lvl);
        return in_w + lvl;
    endfunction

    // Number of elements entering tree level lvl: ceil(num_in / 2^lvl).
    function automatic int level_n(input int num_in, input int lvl);
        return (num_in + (1 << lvl) - 1) >> lvl;
    endfunction

    // Per-beat control carried down the pipe next to the tree data.
    typedef struct packed {
        logic valid;
        logic relu_en;
    } ctl_t;

endpackage

// File: rtl/adder_tree_pipe_if.sv
// -----------------------------------------------------------------------------
// adder_tree_pipe_if
// Valid/ready stream bundle for adder_tree_pipe. Signal names keep the i_/o_
// direction prefix as seen from the pipe itself.
//   i_valid/o_ready     upstream handshake
//   i_data              NUM_IN packed operands, operand k at [k*IN_W +: IN_W]
//   i_bias, i_relu_en   sideband sampled with the beat
//   o_valid/i_ready     downstream handshake
//   o_data              OUT_W-bit activation
// slave  = the pipe's view; master = the producer/consumer environment.
// -----------------------------------------------------------------------------
interface adder_tree_pipe_if #(
    parameter int NUM_IN = 9,
    parameter int IN_W   = 20,
    parameter int OUT_W  = 10
);
    logic                     i_valid;
    logic                     o_ready;
    logic [NUM_IN*IN_W-1:0]   i_data;
    logic [IN_W-1:0]          i_bias;
    logic                     i_relu_en;
    logic                     o_valid;
    logic                     i_ready;
    logic [OUT_W-1:0]         o_data;

    modport slave (
        input  i_valid, i_data, i_bias, i_relu_en, i_ready,
        output o_ready, o_valid, o_data
    );

    modport master (
        output i_valid, i_data, i_bias, i_relu_en, i_ready,
        input  o_ready, o_valid, o_data
    );
endinterface

// File: rtl/adder_tree_pipe_level.sv
// -----------------------------------------------------------------------------
// adder_tree_level
// One registered level of the adder tree: adds adjacent pairs of N_IN signed
// W_IN-bit elements into ceil(N_IN/2) elements of W_IN+1 bits. An odd last
// element is sign-extended and passed through the same register.
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_en             advance enable (low = hold, pipe stalled)
//   i_data           N_IN packed elements, element k at [k*W_IN +: W_IN]
//   o_data           N_OUT packed elements of W_OUT bits
// -----------------------------------------------------------------------------
module adder_tree_level
    import adder_tree_pkg::*;
#(
    parameter int N_IN  = 9,
    parameter int W_IN  = 20,
    localparam int N_OUT = level_n(N_IN, 1),
    localparam int W_OUT = level_w(W_IN, 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    input  logic [N_IN*W_IN-1:0]   i_data,
    output logic [N_OUT*W_OUT-1:0] o_data
);

    logic [N_OUT*W_OUT-1:0] w_next;
    logic [N_OUT*W_OUT-1:0] r_data;

    for (genvar k = 0; k < N_OUT; k++) begin : g_elem
        logic [W_IN-1:0] w_a;
        assign w_a = i_data[2*k*W_IN +: W_IN];

        if (2 * k + 1 < N_IN) begin : g_pair
            logic [W_IN-1:0] w_b;
            assign w_b = i_data[(2*k+1)*W_IN +: W_IN];
            // One extra bit on each side makes the pairwise sum exact.
            assign w_next[k*W_OUT +: W_OUT] = {w_a[W_IN-1], w_a} + {w_b[W_IN-1], w_b};
        end else begin : g_odd
            assign w_next[k*W_OUT +: W_OUT] = {w_a[W_IN-1], w_a};
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values and simulation order between always_ff blocks is irrelevant.
    // NOTE: data registers are reset too, so o_data reads 0 after reset rather
    // than stale values from before it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
        end else if (i_en) begin
            r_data <= w_next;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/adder_tree_pipe.sv
// -----------------------------------------------------------------------------
// adder_tree_pipe
// Pipelined signed adder tree: sums NUM_IN fixed-point products plus a bias,
// then rounds, shifts right by SHIFT, applies optional ReLU and saturates (or
// wraps) to OUT_W bits. One register per tree level plus one output register,
// so a beat emerges LEVELS+1 register stages after it is accepted.
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   bus              adder_tree_pipe_if slave: valid/ready in and out, operands,
//                    bias, relu enable, result
// Backpressure is global: when the output holds a beat the consumer has not
// taken, every stage freezes and o_ready drops.
// -----------------------------------------------------------------------------
module adder_tree_pipe
    import adder_tree_pkg::*;
#(
    parameter int NUM_IN   = 9,
    parameter int IN_W     = 20,
    parameter int OUT_W    = 10,
    parameter int SHIFT    = 10,
    parameter int ROUND_EN = 1,
    parameter int SAT_EN   = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    adder_tree_pipe_if.slave    bus
);

    localparam int LEVELS = levels(NUM_IN);
    localparam int SUM_W  = sum_w(IN_W, NUM_IN);
    localparam int TREE_W = level_w(IN_W, LEVELS);
    // One bit above SUM_W so the rounding increment can never overflow.
    localparam int FW     = SUM_W + 1;

    localparam logic signed [FW-1:0] RND_ADD =
        (ROUND_EN != 0 && SHIFT > 0) ? (FW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [FW-1:0] SAT_MAX = FW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [FW-1:0] SAT_MIN = -SAT_MAX - FW'(1);

    logic                    w_stall;
    logic                    w_en;
    logic [TREE_W-1:0]       w_tree_sum;

    ctl_t                    r_ctl  [LEVELS];
    logic [IN_W-1:0]         r_bias [LEVELS];

    logic signed [FW-1:0]    w_sum;
    logic signed [FW-1:0]    w_rnd;
    logic signed [FW-1:0]    w_shr;
    logic signed [FW-1:0]    w_act;
    logic [OUT_W-1:0]        w_result;

    logic                    r_out_valid;
    logic [OUT_W-1:0]        r_out_data;

    // A beat sitting at the output that is not being taken freezes the pipe.
    assign w_stall     = r_out_valid && !bus.i_ready;
    assign w_en        = !w_stall;
    assign bus.o_ready = w_en;
    assign bus.o_valid = r_out_valid;
    assign bus.o_data  = r_out_data;

    // ---------------------------------------------------------------- tree
    for (genvar g = 0; g < LEVELS; g++) begin : g_tree
        logic [level_n(NUM_IN, g) * level_w(IN_W, g) - 1:0]         w_in;
        logic [level_n(NUM_IN, g + 1) * level_w(IN_W, g + 1) - 1:0] w_out;

        if (g == 0) begin : g_first
            assign w_in = bus.i_data;
        end else begin : g_next
            assign w_in = g_tree[g-1].w_out;
        end

        adder_tree_level #(
            .N_IN (level_n(NUM_IN, g)),
            .W_IN (level_w(IN_W, g))
        ) u_level (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_en    (w_en),
            .i_data  (w_in),
            .o_data  (w_out)
        );
    end

    assign w_tree_sum = g_tree[LEVELS-1].w_out;

    // ------------------------------------------- valid / bias / relu delay
    // Stage 0 samples alongside the first tree level, so entry j lines up
    // with the output of tree level j.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int j = 0; j < LEVELS; j++) begin
                r_ctl[j]  <= '0;
                r_bias[j] <= '0;
            end
        end else if (w_en) begin
            r_ctl[0]  <= '{valid: bus.i_valid, relu_en: bus.i_relu_en};
            r_bias[0] <= bus.i_bias;
            for (int j = 1; j < LEVELS; j++) begin
                r_ctl[j]  <= r_ctl[j-1];
                r_bias[j] <= r_bias[j-1];
            end
        end
    end

    // --------------------------------------------------------- final stage
    // NOTE: every signal driven here gets a value on every path (defaults
    // first), otherwise synthesis infers latches.
    always_comb begin
        w_sum    = '0;
        w_rnd    = '0;
        w_shr    = '0;
        w_act    = '0;
        w_result = '0;

        w_sum = {{(FW-TREE_W){w_tree_sum[TREE_W-1]}}, w_tree_sum}
              + {{(FW-IN_W){r_bias[LEVELS-1][IN_W-1]}}, r_bias[LEVELS-1]};
        w_rnd = w_sum + RND_ADD;
        w_shr = w_rnd >>> SHIFT;

        w_act = w_shr;
        if (r_ctl[LEVELS-1].relu_en && w_shr[FW-1]) begin
            w_act = '0;
        end

        if (SAT_EN != 0) begin
            if (w_act > SAT_MAX) begin
                w_result = SAT_MAX[OUT_W-1:0];
            end else if (w_act < SAT_MIN) begin
                w_result = SAT_MIN[OUT_W-1:0];
            end else begin
                w_result = w_act[OUT_W-1:0];
            end
        end else begin
            w_result = w_act[OUT_W-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_en) begin
            r_out_valid <= r_ctl[LEVELS-1].valid;
            r_out_data  <= w_result;
        end
    end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// -----------------------------------------------------------------------------
// tb_adder_tree_pipe
// Three builds: dut_a (defaults: round, saturate), dut_b (truncate, wrap,
// driven from the same stimulus as dut_a) and dut_c (NUM_IN=4, SHIFT=0).
// A negedge scoreboard predicts every accepted beat with a plain-integer
// model and compares every retired beat in order.
// -----------------------------------------------------------------------------
module tb_adder_tree_pipe;

    localparam int NUM_IN   = 9;
    localparam int NUM_IN_C = 4;
    localparam int IN_W     = 20;
    localparam int OUT_W    = 10;

    typedef logic [NUM_IN*IN_W-1:0]   data_t;
    typedef logic [NUM_IN_C*IN_W-1:0] data_c_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vectors     = 0;
    int n_miscompares = 0;

    adder_tree_pipe_if #(.NUM_IN(NUM_IN),   .IN_W(IN_W), .OUT_W(OUT_W)) bus_a ();
    adder_tree_pipe_if #(.NUM_IN(NUM_IN),   .IN_W(IN_W), .OUT_W(OUT_W)) bus_b ();
    adder_tree_pipe_if #(.NUM_IN(NUM_IN_C), .IN_W(IN_W), .OUT_W(OUT_W)) bus_c ();

    adder_tree_pipe #(.NUM_IN(NUM_IN), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(10),
                      .ROUND_EN(1), .SAT_EN(1))
        dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_a));
    adder_tree_pipe #(.NUM_IN(NUM_IN), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(10),
                      .ROUND_EN(0), .SAT_EN(0))
        dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_b));
    adder_tree_pipe #(.NUM_IN(NUM_IN_C), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(0),
                      .ROUND_EN(1), .SAT_EN(1))
        dut_c (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_c));

    assign bus_b.i_valid   = bus_a.i_valid;
    assign bus_b.i_data    = bus_a.i_data;
    assign bus_b.i_bias    = bus_a.i_bias;
    assign bus_b.i_relu_en = bus_a.i_relu_en;
    assign bus_b.i_ready   = bus_a.i_ready;

    // ------------------------------------------------------ reference model
    function automatic longint floor_div_pow2(input longint v, input int sh);
        longint d;
        longint q;
        d = longint'(1) << sh;
        q = v / d;
        if (v < 0 && q * d != v) q = q - 1;
        return q;
    endfunction

    function automatic longint model(input longint ops[$], input longint bias, input bit relu,
                                     input int shift, input bit round_en, input bit sat_en);
        longint s;
        longint lim;
        s = bias;
        foreach (ops[k]) s += ops[k];
        if (round_en && shift > 0) s += longint'(1) << (shift - 1);
        s = floor_div_pow2(s, shift);
        if (relu && s < 0) s = 0;
        lim = longint'(1) << (OUT_W - 1);
        if (sat_en) begin
            if (s > lim - 1) s = lim - 1;
            else if (s < -lim) s = -lim;
        end
        return s;   // wrap builds keep the low OUT_W bits of this value
    endfunction

    function automatic data_t fill(input longint v);
        data_t d;
        for (int k = 0; k < NUM_IN; k++) d[k*IN_W +: IN_W] = IN_W'(v);
        return d;
    endfunction

    function automatic data_t op0(input longint v);
        data_t d;
        d = '0;
        d[IN_W-1:0] = IN_W'(v);
        return d;
    endfunction

    // ------------------------------------------------------------ scoreboard
    logic [OUT_W-1:0] q_a[$];
    logic [OUT_W-1:0] q_b[$];
    logic [OUT_W-1:0] q_c[$];
    int               ret_a = 0;
    longint           ops_m[$];
    logic [OUT_W-1:0] exp_m;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_a.i_valid && bus_a.o_ready) begin
                ops_m.delete();
                for (int k = 0; k < NUM_IN; k++)
                    ops_m.push_back(longint'($signed(bus_a.i_data[k*IN_W +: IN_W])));
                q_a.push_back(OUT_W'(model(ops_m, longint'($signed(bus_a.i_bias)),
                                           bus_a.i_relu_en, 10, 1'b1, 1'b1)));
                q_b.push_back(OUT_W'(model(ops_m, longint'($signed(bus_a.i_bias)),
                                           bus_a.i_relu_en, 10, 1'b0, 1'b0)));
            end
            if (bus_c.i_valid && bus_c.o_ready) begin
                ops_m.delete();
                for (int k = 0; k < NUM_IN_C; k++)
                    ops_m.push_back(longint'($signed(bus_c.i_data[k*IN_W +: IN_W])));
                q_c.push_back(OUT_W'(model(ops_m, longint'($signed(bus_c.i_bias)),
                                           bus_c.i_relu_en, 0, 1'b1, 1'b1)));
            end
            if (bus_a.o_valid && bus_a.i_ready) begin
                n_vectors++;
                ret_a++;
                if (q_a.size() == 0) begin
                    n_miscompares++;
                    $display("FAIL sb_a: unexpected beat o_data=%0d, expected no beat", $signed(bus_a.o_data));
                end else begin
                    exp_m = q_a.pop_front();
                    if (bus_a.o_data !== exp_m) begin
                        n_miscompares++;
                        $display("FAIL sb_a: o_data=%0d expected %0d", $signed(bus_a.o_data), $signed(exp_m));
                    end
                end
            end
            if (bus_b.o_valid && bus_b.i_ready) begin
                n_vectors++;
                if (q_b.size() == 0) begin
                    n_miscompares++;
                    $display("FAIL sb_b: unexpected beat o_data=%0d, expected no beat", $signed(bus_b.o_data));
                end else begin
                    exp_m = q_b.pop_front();
                    if (bus_b.o_data !== exp_m) begin
                        n_miscompares++;
                        $display("FAIL sb_b: o_data=%0d expected %0d", $signed(bus_b.o_data), $signed(exp_m));
                    end
                end
            end
            if (bus_c.o_valid && bus_c.i_ready) begin
                n_vectors++;
                if (q_c.size() == 0) begin
                    n_miscompares++;
                    $display("FAIL sb_c: unexpected beat o_data=%0d, expected no beat", $signed(bus_c.o_data));
                end else begin
                    exp_m = q_c.pop_front();
                    if (bus_c.o_data !== exp_m) begin
                        n_miscompares++;
                        $display("FAIL sb_c: o_data=%0d expected %0d", $signed(bus_c.o_data), $signed(exp_m));
                    end
                end
            end
        end
    end

    // --------------------------------------------------------------- helpers
    task automatic drive_a(input data_t d, input logic [IN_W-1:0] b, input logic r);
        bus_a.i_valid   = 1'b1;
        bus_a.i_data    = d;
        bus_a.i_bias    = b;
        bus_a.i_relu_en = r;
    endtask

    // Single beat on an idle pipe; checks the cycle count and both results.
    task automatic run_single(input string name, input data_t d, input logic [IN_W-1:0] b,
                              input logic r, input int exp_a, input int exp_b);
        int n;
        bus_a.i_ready = 1'b1;
        drive_a(d, b, r);
        @(posedge clk); #1;
        bus_a.i_valid = 1'b0;
        n = 1;
        while (!bus_a.o_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        n_vectors++;
        if (n !== 5) begin
            n_miscompares++;
            $display("FAIL %s_latency: o_valid after %0d edges, expected 5", name, n);
        end
        n_vectors++;
        if (bus_a.o_data !== OUT_W'(exp_a)) begin
            n_miscompares++;
            $display("FAIL %s_a: o_data=%0d expected %0d", name, $signed(bus_a.o_data), exp_a);
        end
        n_vectors++;
        if (bus_b.o_data !== OUT_W'(exp_b)) begin
            n_miscompares++;
            $display("FAIL %s_b: o_data=%0d expected %0d", name, $signed(bus_b.o_data), exp_b);
        end
        @(posedge clk); #1;
    endtask

    // ----------------------------------------------------------------- tests
    task automatic test_reset();
        bus_a.i_valid = 1'b0; bus_a.i_data = '0; bus_a.i_bias = '0; bus_a.i_relu_en = 1'b0;
        bus_a.i_ready = 1'b0;
        bus_c.i_valid = 1'b0; bus_c.i_data = '0; bus_c.i_bias = '0; bus_c.i_relu_en = 1'b0;
        bus_c.i_ready = 1'b0;
        rst_n = 1'b0;
        #22;
        n_vectors++;
        if (bus_a.o_valid !== 1'b0) begin n_miscompares++; $display("FAIL rst_valid_a: %b expected 0", bus_a.o_valid); end
        n_vectors++;
        if (bus_a.o_data !== '0) begin n_miscompares++; $display("FAIL rst_data_a: %0d expected 0", bus_a.o_data); end
        n_vectors++;
        if (bus_a.o_ready !== 1'b1) begin n_miscompares++; $display("FAIL rst_ready_a: %b expected 1", bus_a.o_ready); end
        n_vectors++;
        if (bus_b.o_valid !== 1'b0) begin n_miscompares++; $display("FAIL rst_valid_b: %b expected 0", bus_b.o_valid); end
        n_vectors++;
        if (bus_c.o_valid !== 1'b0 || bus_c.o_data !== '0) begin
            n_miscompares++;
            $display("FAIL rst_c: valid=%b data=%0d expected 0/0", bus_c.o_valid, bus_c.o_data);
        end
        bus_a.i_ready = 1'b1;
        bus_c.i_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_single("ones",      fill(1024),    '0, 1'b0, 9, 9);
        run_single("half_lsb",  op0(512),      '0, 1'b0, 1, 0);
        run_single("sat_pos",   fill(262143),  '0, 1'b0, 511, 255);
        run_single("sat_neg",   fill(-262144), '0, 1'b0, -512, -256);
        run_single("neg",       fill(-1024),   '0, 1'b0, -9, -9);
        run_single("neg_relu",  fill(-1024),   '0, 1'b1, 0, 0);
        run_single("pos_relu",  fill(1024),    '0, 1'b1, 9, 9);
        run_single("bias_relu", fill(1024),    IN_W'(-10240), 1'b1, 0, 0);
        run_single("bias_neg",  fill(1024),    IN_W'(-10240), 1'b0, -1, -1);
    endtask

    task automatic test_stream();
        int sent, cyc, stall_cycles, start_ret;
        logic [OUT_W-1:0] held;
        logic prev_stall;
        sent = 0; cyc = 0; stall_cycles = 0; start_ret = ret_a;
        held = '0; prev_stall = 1'b0;
        while ((sent < 20 || q_a.size() != 0) && cyc < 200) begin
            bus_a.i_ready = !(cyc >= 8 && cyc < 11);
            if (sent < 20) drive_a(op0(sent * 1024), '0, 1'b0);
            else           bus_a.i_valid = 1'b0;
            @(negedge clk);
            if (bus_a.o_valid && !bus_a.i_ready) begin
                stall_cycles++;
                n_vectors++;
                if (bus_a.o_ready !== 1'b0) begin
                    n_miscompares++;
                    $display("FAIL stall_ready: o_ready=%b expected 0", bus_a.o_ready);
                end
                if (prev_stall) begin
                    n_vectors++;
                    if (bus_a.o_data !== held) begin
                        n_miscompares++;
                        $display("FAIL stall_hold: o_data=%0d expected %0d", bus_a.o_data, held);
                    end
                end
                held = bus_a.o_data;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (bus_a.i_valid && bus_a.o_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        bus_a.i_valid = 1'b0;
        bus_a.i_ready = 1'b1;
        n_vectors++;
        if (ret_a - start_ret !== 20) begin
            n_miscompares++;
            $display("FAIL stream_count: %0d beats out expected 20", ret_a - start_ret);
        end
        n_vectors++;
        if (stall_cycles !== 3) begin
            n_miscompares++;
            $display("FAIL stream_stalls: %0d stalled cycles expected 3", stall_cycles);
        end
    endtask

    task automatic test_random();
        int sent, cyc, v;
        data_t d;
        sent = 0; cyc = 0;
        while ((sent < 60 || q_a.size() != 0) && cyc < 2000) begin
            bus_a.i_ready = ($urandom_range(3) != 0);
            if (sent < 60 && $urandom_range(3) != 0) begin
                for (int k = 0; k < NUM_IN; k++) begin
                    if ($urandom_range(1) != 0) v = int'($urandom_range(8191)) - 4096;
                    else                        v = int'($urandom);
                    d[k*IN_W +: IN_W] = IN_W'(v);
                end
                drive_a(d, IN_W'($urandom), 1'($urandom_range(1)));
            end else begin
                bus_a.i_valid = 1'b0;
            end
            @(negedge clk);
            if (bus_a.i_valid && bus_a.o_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        bus_a.i_valid = 1'b0;
        bus_a.i_ready = 1'b1;
        n_vectors++;
        if (q_a.size() != 0 || sent != 60) begin
            n_miscompares++;
            $display("FAIL random_drain: sent=%0d pending=%0d expected 60/0", sent, q_a.size());
        end
    endtask

    task automatic test_reset_midstream();
        int ghosts;
        bus_a.i_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_a(op0((i + 1) * 2048), '0, 1'b0);
            @(posedge clk); #1;
        end
        bus_a.i_valid = 1'b0;
        n_vectors++;
        if (bus_a.o_valid !== 1'b1) begin
            n_miscompares++;
            $display("FAIL pre_reset_valid: o_valid=%b expected 1", bus_a.o_valid);
        end
        rst_n = 1'b0;
        q_a.delete(); q_b.delete(); q_c.delete();
        #1;
        n_vectors++;
        if (bus_a.o_valid !== 1'b0 || bus_b.o_valid !== 1'b0) begin
            n_miscompares++;
            $display("FAIL async_reset_valid: a=%b b=%b expected 0/0", bus_a.o_valid, bus_b.o_valid);
        end
        n_vectors++;
        if (bus_a.o_data !== '0) begin
            n_miscompares++;
            $display("FAIL async_reset_data: o_data=%0d expected 0", bus_a.o_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        ghosts = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus_a.o_valid) ghosts++;
        end
        n_vectors++;
        if (ghosts !== 0) begin
            n_miscompares++;
            $display("FAIL reset_discard: %0d valid cycles after reset expected 0", ghosts);
        end
        run_single("post_reset", fill(2048), '0, 1'b0, 18, 18);
    endtask

    task automatic test_num_in4();
        int n;
        data_c_t d [4];
        int      b [4];
        logic    r [4];
        int      e [4];
        d[0] = {20'd4, 20'd3, 20'd2, 20'd1};                b[0] = 0; r[0] = 1'b0; e[0] = 10;
        d[1] = {20'd3, 20'hFFF9C, 20'd7, 20'hFFFFB};        b[1] = 0; r[1] = 1'b0; e[1] = -95;
        d[2] = {20'd3, 20'hFFF9C, 20'd7, 20'hFFFFB};        b[2] = 0; r[2] = 1'b1; e[2] = 0;
        d[3] = {4{20'd200000}};                             b[3] = -7; r[3] = 1'b0; e[3] = 511;
        bus_c.i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_c.i_valid   = 1'b1;
            bus_c.i_data    = d[i];
            bus_c.i_bias    = IN_W'(b[i]);
            bus_c.i_relu_en = r[i];
            @(posedge clk); #1;
            bus_c.i_valid = 1'b0;
            n = 1;
            while (!bus_c.o_valid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            n_vectors++;
            if (n !== 3) begin
                n_miscompares++;
                $display("FAIL n4_latency_%0d: o_valid after %0d edges expected 3", i, n);
            end
            n_vectors++;
            if (bus_c.o_data !== OUT_W'(e[i])) begin
                n_miscompares++;
                $display("FAIL n4_data_%0d: o_data=%0d expected %0d", i, $signed(bus_c.o_data), e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_drain();
        repeat (8) begin @(posedge clk); #1; end
        n_vectors++;
        if (q_a.size() != 0 || q_b.size() != 0 || q_c.size() != 0) begin
            n_miscompares++;
            $display("FAIL drain: pending a=%0d b=%0d c=%0d expected 0", q_a.size(), q_b.size(), q_c.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stream();
        test_random();
        test_reset_midstream();
        test_num_in4();
        test_drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
